// File: rtl/score_pkg.sv
// Shared constants for the score_board_n display path: BCD digit width and
// active-high seven-segment patterns ordered {g,f,e,d,c,b,a}.
package score_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;  // a,b,c only
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high seven-segment decoder; codes A-F blank.
module seg7_decode
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  // Map one BCD code to its segment pattern
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_board_n.sv
// N-digit BCD score keeper with saturating count, clear-on-lose and a
// multiplexed seven-segment scan driver. Define SCORE_HISCORE_EN to build the
// high-score register, its compare-on-lose update and the show_hi display mux.
module score_board_n
  import score_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_CYCLES = 50000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                    mclk,
  input  logic                    rst,
  input  logic                    hit,
  input  logic                    lose,
  input  logic                    show_hi,
  output logic [BCD_W*DIGITS-1:0] score_bcd,
  output logic                    sat,
  output logic [DIGITS-1:0]       select,
  output logic [6:0]              seg
);

  localparam int unsigned ScoreW = BCD_W * DIGITS;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PreW   = $clog2(SCAN_CYCLES);
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  logic              hit_q, lose_q;
  logic              hit_ev, lose_ev;
  logic [ScoreW-1:0] score_q, score_d, score_inc, disp;
  logic              all_nines;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BCD_W-1:0]  nibble;
  logic [6:0]        seg_act, seg_q;
  logic [DIGITS-1:0] sel_act, select_q;

  assign hit_ev  = hit & ~hit_q;
  assign lose_ev = lose & ~lose_q;

  // Edge-detect history for the event inputs
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      hit_q  <= hit;
      lose_q <= lose;
    end
  end

  // Ripple-carry BCD increment and all-nines detect
  always_comb begin
    logic carry;
    score_inc = score_q;
    all_nines = 1'b1;
    carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (score_q[i*BCD_W +: BCD_W] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (score_q[i*BCD_W +: BCD_W] == 4'd9) begin
          score_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          score_inc[i*BCD_W +: BCD_W] = score_q[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Lose has priority over a same-cycle hit; hits at all nines are dropped
  always_comb begin
    score_d = score_q;
    if (lose_ev) begin
      score_d = '0;
    end else if (hit_ev && !all_nines) begin
      score_d = score_inc;
    end
  end

  // Current score register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end

  assign score_bcd = score_q;
  assign sat       = all_nines;

`ifdef SCORE_HISCORE_EN
  logic [ScoreW-1:0] hi_q, hi_d;

  // BCD ordering matches binary ordering, so a plain compare is enough
  always_comb begin
    hi_d = hi_q;
    if (lose_ev && (score_q > hi_q)) hi_d = score_q;
  end

  // High-score register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) hi_q <= '0;
    else     hi_q <= hi_d;
  end

  assign disp = show_hi ? hi_q : score_q;
`else
  logic unused_show_hi;
  assign unused_show_hi = show_hi;
  assign disp           = score_q;
`endif

  // Prescaler and digit index advance
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PreMax) begin
      pre_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Scan counters
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  // Digit mux and one-hot select for the current index
  always_comb begin
    nibble         = disp[int'(idx_q)*BCD_W +: BCD_W];
    sel_act        = '0;
    sel_act[idx_q] = 1'b1;
  end

  seg7_decode u_seg7_decode (
    .bcd_i (nibble),
    .seg_o (seg_act)
  );

  // Output registers with polarity applied; reset to the inactive level
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      select_q <= {DIGITS{ACTIVE_LOW}};
      seg_q    <= {7{ACTIVE_LOW}};
    end else begin
      select_q <= sel_act ^ {DIGITS{ACTIVE_LOW}};
      seg_q    <= seg_act ^ {7{ACTIVE_LOW}};
    end
  end

  assign select = select_q;
  assign seg    = seg_q;

endmodule

// File: doc/score_board_n.md
# score_board_n

Parametrised score keeper and multiplexed seven-segment driver for the game top level, the next generation of the fixed 4-digit scoreboard. It keeps an N-digit BCD score that is incremented by `hit` events and cleared by `lose` events, saturating at all nines. It also keeps an optional high-score register. It time-multiplexes the selected value onto a shared segment bus with a one-hot digit select.

## Interface
- `DIGITS`, 4: number of BCD digits and select lines; must be 1–8.
- `SCAN_CYCLES`, 50000: `mclk` cycles each digit stays selected; must be ≥2.
- `ACTIVE_LOW`, 1: if 1, `seg` and `select` are active-low; if 0, active-high.
- `mclk`  in  1: system clock. One clock domain.
- `rst`  in  1: reset, asynchronous and active-high.
- `hit`  in  1: score event, synchronous to `mclk`. Each rising edge adds 1.
- `lose`  in  1: game-over event, synchronous to `mclk`. Each rising edge clears the score.
- `show_hi`  in  1: level input. 1 displays the high score, 0 displays the current score.
- `score_bcd`  out  4*DIGITS: current score; digit 0 is in bits [3:0].
- `sat`  out  1: 1 while the score is all nines.
- `select`  out  DIGITS: one-hot digit enable; bit 0 is the least significant digit.
- `seg`  out  7: segment pattern `{g,f,e,d,c,b,a}`.

## Operation
- Edge detect: `hit` and `lose` are each registered once. An event is input=1 while the registered copy=0. A held-high level counts once.
- Hit event: the BCD score increments with a ripple carry (9→0 carries up).
  - If the score is all nines, the hit is ignored and the score stays; `sat` stays 1.
- Lose event:
  - With `SCORE_HISCORE_EN`: if the current score > high score, the high score takes the current score.
  - In all cases the score is then cleared to 0.
- Hit and lose in the same cycle: lose wins and the hit is discarded.
- Scan:
  - A prescaler counts 0..SCAN_CYCLES-1.
  - On its wrap, the digit index advances; DIGITS-1 wraps to 0.
  - For `DIGITS`=1 the index stays at 0.
- Display value: the high score when `show_hi`=1 and `SCORE_HISCORE_EN` is defined, otherwise `score_bcd`. The indexed nibble is decoded to 7 segments.
- Decode: 0–9 use the standard patterns, with "7" lit as a,b,c. Codes A–F are blank (all segments off).
- Polarity: with `ACTIVE_LOW`=1 both `seg` and `select` are inverted at the output register.

## Timing
- Reset values: score 0, high score 0, prescaler 0, index 0, edge registers 0, `sat`=0.
- Output registers reset inactive: `select` all inactive, `seg` all off (all 1 when `ACTIVE_LOW`=1).
- Event latency: `hit` rises at cycle n → `score_bcd` changes at n+1. `sat` is combinational from `score_bcd`.
- Display latency: `select`/`seg` are registered and lag the digit index by 1 cycle.
  - The first digit 0 appears 1 cycle after reset release.
- Each digit is shown for exactly SCAN_CYCLES cycles. The full frame is DIGITS*SCAN_CYCLES cycles.
- A `show_hi` change is visible on `seg` 1 cycle later; the index is not affected.
- Reset mid-operation clears all state immediately. Events in flight are lost.

## Configuration
- `SCORE_HISCORE_EN` defined: the high-score register, the compare-on-lose logic and the `show_hi` mux are built.
- `SCORE_HISCORE_EN` undefined: none of that logic exists. `show_hi` is ignored and the current score is always displayed.

## Structure
- Package `score_pkg` holds:
  - the 7-bit segment pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK` (active-high form);
  - the BCD digit width constant `BCD_W`=4.
- Sub-module `seg7_decode`: combinational 4-bit BCD to active-high 7-segment decoder. It is instantiated once, after the digit mux.
- Polarity inversion and output registers stay in `score_board_n`.

## Test plan
All scenarios use DIGITS=4, SCAN_CYCLES=4, ACTIVE_LOW=1, `SCORE_HISCORE_EN` defined unless stated.
- Reset: hold `rst`, release. Expect `select`=4'b1111 and `seg`=7'h7F during reset. Expect `select`=4'b1110, `seg`=~SEG_0 from the 1st cycle after release; the digit advances every 4 cycles and the sequence wraps after 16 cycles.
- Count: 12 single-cycle `hit` pulses → `score_bcd`=16'h0012. A `hit` held high 10 cycles → +1 only.
- Saturate: preload 9999 via 9999 hits → `sat`=1. One more hit → score stays 16'h9999.
- High score:
  - 37 hits, then `lose` → score 0, high score 0037.
  - 5 hits, then `lose` → high score still 0037.
  - `show_hi`=1 → digit 0 shows ~SEG_7, digit 1 shows ~SEG_3.
- Same-cycle events: at score 0005, `hit` and `lose` rise together → score 0000 next cycle. High score becomes 0005 if it was below 5.
- Macro off: rebuild without `SCORE_HISCORE_EN`, 8 hits, `show_hi`=1 → the display still shows 0008.
